// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: round-robin owner of one SPI flash bus for two requesters,
// with an enforced chip-select-high gap between owners and an optional hold watchdog.
module spi_flash_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  output logic gnt0,
  input  logic spi_csel0,
  input  logic spi_clk0,
  input  logic spi_mosi0,
  output logic spi_miso0,
  input  logic req1,
  output logic gnt1,
  input  logic spi_csel1,
  input  logic spi_clk1,
  input  logic spi_mosi1,
  output logic spi_miso1,
  output logic spi_csel,
  output logic spi_clk,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic busy,
  output logic timeout_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [1:0]  lockout_q, lockout_d;
  logic [23:0] hold_q, hold_d;
  logic [7:0]  gap_q, gap_d;
  logic        timeout_err_q, timeout_err_d;
  logic [1:0]  elig;
  logic        arb_valid, arb_sel, own_sel, own_req, owning, hold_hit, can_grant;
  always_comb begin
    elig      = {req1 & ~lockout_q[1], req0 & ~lockout_q[0]};
    arb_valid = |elig;
    // on a tie the requester that did not own the bus last wins
    arb_sel   = (elig == 2'b11) ? ~last_q : elig[1];
    owning    = (state_q == OWN0) || (state_q == OWN1);
    own_sel   = (state_q == OWN1);
    own_req   = own_sel ? req1 : req0;
    hold_hit  = (TIMEOUT_CYCLES != 0) && (hold_q == 24'(TIMEOUT_CYCLES - 1));
    can_grant = (state_q == IDLE) || ((state_q == GAP) && (gap_q == 8'd0));
    state_d       = state_q;
    last_d        = last_q;
    hold_d        = hold_q;
    gap_d         = gap_q;
    timeout_err_d = 1'b0;
    lockout_d     = lockout_q & {req1, req0};
    if (owning) begin
      if (!own_req) begin
        state_d = GAP;
        gap_d   = 8'(GAP_CYCLES - 1);
      end else if (hold_hit) begin
        state_d            = GAP;
        gap_d              = 8'(GAP_CYCLES - 1);
        timeout_err_d      = 1'b1;
        lockout_d[own_sel] = 1'b1;
      end else begin
        hold_d = (hold_q == 24'hFF_FFFF) ? hold_q : hold_q + 24'd1;
      end
    end else if (can_grant) begin
      state_d = arb_valid ? (arb_sel ? OWN1 : OWN0) : IDLE;
      last_d  = arb_valid ? arb_sel : last_q;
      hold_d  = arb_valid ? 24'd0 : hold_q;
    end else begin
      gap_d = gap_q - 8'd1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      lockout_q     <= 2'b00;
      hold_q        <= 24'd0;
      gap_q         <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      lockout_q     <= lockout_d;
      hold_q        <= hold_d;
      gap_q         <= gap_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign gnt0        = (state_q == OWN0);
  assign gnt1        = (state_q == OWN1);
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;
  assign spi_csel    = gnt0 ? spi_csel0 : gnt1 ? spi_csel1 : 1'b1;
  assign spi_clk     = gnt0 ? spi_clk0  : gnt1 ? spi_clk1  : 1'b0;
  assign spi_mosi    = gnt0 ? spi_mosi0 : gnt1 ? spi_mosi1 : 1'b0;
  assign spi_miso0   = gnt0 & spi_miso;
  assign spi_miso1   = gnt1 & spi_miso;
endmodule
